redmule_mx_exp_writer: RTL and testbench

Controller that drains the MX shared-exponent stream produced by the RedMulE MX encoder and stores it in TCDM.
- Accepts one 8-bit exponent per stream handshake.
- Packs exponents four per 32-bit word, little-endian byte lanes.
- Sequences word writes onto a dedicated 32-bit TCDM master port, starting at a configured base address.
- Sits in redmule_top between the MX encoder exponent output and the TCDM interconnect. It replaces the always-ready exponent sink.

---
 rtl/redmule_pkg.sv | 12 +
 rtl/redmule_mx_exp_packer.sv | 29 ++
 rtl/redmule_mx_exp_writer.sv | 87 ++++++++
 tb/tb_redmule_mx_exp_writer.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/redmule_pkg.sv
// redmule_pkg: constants and types shared by the RedMulE MX exponent writer.
package redmule_pkg;
   localparam int unsigned MX_EXP_W    = 8;
   localparam int unsigned MX_EXP_PACK = 32 / MX_EXP_W;

   typedef enum logic [1:0] {IDLE, COLLECT, WRITE, DONE} mx_exp_wr_state_e;

   typedef struct packed {
      logic [31:0] base_addr;
      logic [15:0] num_exp;
   } mx_exp_wr_cfg_t;
endpackage

// File: rtl/redmule_mx_exp_packer.sv
// redmule_mx_exp_packer: gathers exponents into little-endian byte lanes of one 32-bit word.
module redmule_mx_exp_packer
   import redmule_pkg::*;
(
   input  logic                   clk_i,
   input  logic                   rst_ni,
   input  logic                   clear,
   input  logic                   load,
   input  logic [MX_EXP_W-1:0]    data,
   output logic [31:0]            word,
   output logic [MX_EXP_PACK-1:0] be,
   output logic [1:0]             lane
);
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         word <= '0;
         be   <= '0;
         lane <= '0;
      end else if (clear) begin
         word <= '0;
         be   <= '0;
         lane <= '0;
      end else if (load) begin
         word[{lane, 3'b000} +: MX_EXP_W] <= data;
         be[lane]                         <= 1'b1;
         lane                             <= lane + 2'd1;
      end
   end
endmodule

// File: rtl/redmule_mx_exp_writer.sv
// redmule_mx_exp_writer: drains the MX shared-exponent stream and writes it,
// four exponents per word, to TCDM starting at a configured base address.
module redmule_mx_exp_writer
   import redmule_pkg::*;
#(
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned CNT_W  = 16,
   parameter int unsigned EXP_W  = MX_EXP_W
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              clear_i,
   input  logic              start_i,
   input  logic [ADDR_W-1:0] base_addr_i,
   input  logic [CNT_W-1:0]  num_exp_i,
   input  logic              exp_valid_i,
   input  logic [31:0]       exp_data_i,
   output logic              exp_ready_o,
   output logic              tcdm_req_o,
   input  logic              tcdm_gnt_i,
   output logic [ADDR_W-1:0] tcdm_add_o,
   output logic              tcdm_wen_o,
   output logic [3:0]        tcdm_be_o,
   output logic [31:0]       tcdm_data_o,
   output logic              busy_o,
   output logic              done_o
);
   mx_exp_wr_state_e  state_q, state_d;
   logic [ADDR_W-1:0] addr_q;
   logic [CNT_W-1:0]  rem_q;
   logic [1:0]        lane;
   logic              hs, launch, pk_clear, unused_bits;

   assign exp_ready_o = state_q == COLLECT;
   assign tcdm_req_o  = state_q == WRITE;
   assign busy_o      = state_q != IDLE;
   assign done_o      = state_q == DONE;
   assign tcdm_wen_o  = 1'b0;
   assign tcdm_add_o  = addr_q;
   assign hs          = exp_ready_o & exp_valid_i;
   assign launch      = (state_q == IDLE) & start_i;
   assign pk_clear    = clear_i | launch | (tcdm_req_o & tcdm_gnt_i);
   assign unused_bits = ^{exp_data_i[31:EXP_W], base_addr_i[1:0]};

   redmule_mx_exp_packer i_packer (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .clear  (pk_clear),
      .load   (hs),
      .data   (exp_data_i[EXP_W-1:0]),
      .word   (tcdm_data_o),
      .be     (tcdm_be_o),
      .lane   (lane)
   );

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= IDLE;
         addr_q  <= '0;
         rem_q   <= '0;
      end else begin
         state_q <= state_d;
         if (!clear_i) begin
            if (launch) begin
               addr_q <= {base_addr_i[ADDR_W-1:2], 2'b00};
               rem_q  <= num_exp_i;
            end else if (hs) begin
               rem_q  <= rem_q - CNT_W'(1);
            end else if (tcdm_req_o && tcdm_gnt_i) begin
               addr_q <= addr_q + ADDR_W'(4);
            end
         end
      end
   end

   // A word is flushed when its last lane fills or the job runs out of exponents
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start_i) state_d = (num_exp_i == '0) ? DONE : COLLECT;
         COLLECT: if (hs && (lane == 2'd3 || rem_q == CNT_W'(1))) state_d = WRITE;
         WRITE:   if (tcdm_gnt_i) state_d = (rem_q != '0) ? COLLECT : DONE;
         default: state_d = IDLE;
      endcase
      if (clear_i) state_d = IDLE;
   end
endmodule

// File: tb/tb_redmule_mx_exp_writer.sv
// tb_redmule_mx_exp_writer: randomized scoreboard bench for the MX exponent writer;
// expected TCDM writes are derived from the job's exponent list and base address.
module tb_redmule_mx_exp_writer;
   typedef struct packed {
      logic [31:0] addr;
      logic [31:0] data;
      logic [3:0]  be;
   } wr_t;

   logic        clk = 1'b0, rst_ni = 1'b0, clear_i = 1'b0, start_i = 1'b0;
   logic [31:0] base_addr_i = '0, exp_data_i, tcdm_add_o, tcdm_data_o;
   logic [15:0] num_exp_i = '0;
   logic        exp_valid_i, exp_ready_o, tcdm_req_o, tcdm_gnt_i, tcdm_wen_o, busy_o, done_o;
   logic [3:0]  tcdm_be_o;

   int   checks = 0, errors = 0;
   wr_t  sb[$];
   logic [7:0] exps[$];
   int   job_id = 0, prod_job = 0, accepted = 0;
   int   val_pct = 100, gnt_pct = 100, stall_cycles = 0;
   int   cyc = 0, req_cnt = 0, done_cnt = 0, busy_cnt = 0, stall_cnt = 0;
   int   last_gnt_cyc = 0, done_cyc = 0, d0 = 0;

   always #5 clk = ~clk;

   redmule_mx_exp_writer dut (
      .clk_i       (clk),
      .rst_ni      (rst_ni),
      .clear_i     (clear_i),
      .start_i     (start_i),
      .base_addr_i (base_addr_i),
      .num_exp_i   (num_exp_i),
      .exp_valid_i (exp_valid_i),
      .exp_data_i  (exp_data_i),
      .exp_ready_o (exp_ready_o),
      .tcdm_req_o  (tcdm_req_o),
      .tcdm_gnt_i  (tcdm_gnt_i),
      .tcdm_add_o  (tcdm_add_o),
      .tcdm_wen_o  (tcdm_wen_o),
      .tcdm_be_o   (tcdm_be_o),
      .tcdm_data_o (tcdm_data_o),
      .busy_o      (busy_o),
      .done_o      (done_o)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   // Producer: presents the current job's exponents, holding data until accepted
   initial begin : producer
      int   idx = 0;
      logic hs;
      exp_valid_i = 1'b0;
      exp_data_i  = '0;
      forever begin
         @(negedge clk);
         hs = exp_valid_i && exp_ready_o;
         @(posedge clk);
         #1;
         if (prod_job != job_id) begin
            prod_job    = job_id;
            idx         = 0;
            accepted    = 0;
            exp_valid_i = 1'b0;
         end else if (hs) begin
            idx++;
            accepted    = idx;
            exp_valid_i = 1'b0;
         end
         if (!exp_valid_i && idx < exps.size() && $urandom_range(99) < val_pct) begin
            exp_valid_i = 1'b1;
            exp_data_i  = {24'($urandom()), exps[idx]};
         end
      end
   end

   initial begin : granter
      int my_job = 0, stalled = 0;
      tcdm_gnt_i = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         if (my_job != job_id) begin
            my_job  = job_id;
            stalled = 0;
         end
         if (stalled < stall_cycles && tcdm_req_o) begin
            tcdm_gnt_i = 1'b0;
            stalled++;
         end else begin
            tcdm_gnt_i = $urandom_range(99) < gnt_pct;
         end
      end
   end

   initial begin : monitor
      logic        stalled = 1'b0;
      logic [31:0] pa = '0, pd = '0;
      logic [3:0]  pb = '0;
      wr_t         e;
      forever begin
         @(negedge clk);
         cyc++;
         if (busy_o) busy_cnt++;
         if (done_o) begin
            done_cnt++;
            done_cyc = cyc;
         end
         if (!busy_o) chk("ready_idle", 32'(exp_ready_o), 32'd0);
         if (stalled && rst_ni) begin
            chk("stall_req", 32'(tcdm_req_o), 32'd1);
            chk("stall_add", tcdm_add_o, pa);
            chk("stall_data", tcdm_data_o, pd);
            chk("stall_be", 32'(tcdm_be_o), 32'(pb));
         end
         if (tcdm_req_o) begin
            chk("ready_in_write", 32'(exp_ready_o), 32'd0);
            chk("wen", 32'(tcdm_wen_o), 32'd0);
            if (!tcdm_gnt_i) stall_cnt++;
            if (tcdm_gnt_i) begin
               req_cnt++;
               last_gnt_cyc = cyc;
               if (sb.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_write: got add %h data %h be %h, expected no write",
                           tcdm_add_o, tcdm_data_o, tcdm_be_o);
               end else begin
                  e = sb.pop_front();
                  chk("wr_add", tcdm_add_o, e.addr);
                  chk("wr_data", tcdm_data_o, e.data);
                  chk("wr_be", 32'(tcdm_be_o), 32'(e.be));
               end
            end
         end
         stalled = tcdm_req_o && !tcdm_gnt_i;
         pa      = tcdm_add_o;
         pd      = tcdm_data_o;
         pb      = tcdm_be_o;
      end
   end

   // Reference: word w holds exponents 4w..4w+3 at base+4w, one byte enable per present exponent
   task automatic push_model(input logic [31:0] base);
      wr_t x;
      for (int w = 0; w * 4 < exps.size(); w++) begin
         x.addr = (base & ~32'h3) + 32'(4 * w);
         x.data = '0;
         x.be   = '0;
         for (int k = 0; k < 4 && w * 4 + k < exps.size(); k++) begin
            x.data = x.data | (32'(exps[w * 4 + k]) << (8 * k));
            x.be   = x.be | 4'(1 << k);
         end
         sb.push_back(x);
      end
   endtask

   task automatic start_job(input logic [31:0] base, input int n, input bit rnd, input bit expect_writes);
      exps.delete();
      for (int i = 0; i < n; i++) exps.push_back(rnd ? 8'($urandom()) : 8'(i + 1));
      if (expect_writes) push_model(base);
      job_id++;
      d0          = done_cnt;
      start_i     = 1'b1;
      base_addr_i = base;
      num_exp_i   = 16'(n);
      tick();
      start_i     = 1'b0;
      base_addr_i = $urandom();
      num_exp_i   = 16'($urandom());
   endtask

   task automatic finish_job(input string name);
      int t = 0;
      while (done_cnt == d0 && t < 5000) begin
         tick();
         t++;
      end
      tick();
      chk({name, "_done_pulses"}, 32'(done_cnt - d0), 32'd1);
      chk({name, "_done_after_gnt"}, 32'(done_cyc), 32'(last_gnt_cyc + 1));
      chk({name, "_sb_empty"}, 32'(sb.size()), 32'd0);
      chk({name, "_idle"}, 32'(busy_o), 32'd0);
   endtask

   initial begin : main
      int r0, b0, t;
      repeat (3) tick();
      chk("rst_req", 32'(tcdm_req_o), 32'd0);
      chk("rst_add", tcdm_add_o, 32'd0);
      chk("rst_data", tcdm_data_o, 32'd0);
      chk("rst_be", 32'(tcdm_be_o), 32'd0);
      chk("rst_busy_done_ready", {29'd0, busy_o, done_o, exp_ready_o}, 32'd0);
      rst_ni = 1'b1;
      tick();
      chk("post_rst_busy", 32'(busy_o), 32'd0);

      r0 = req_cnt;
      start_job(32'h1C010100, 8, 1'b0, 1'b1);
      finish_job("seq8");
      chk("seq8_reqs", 32'(req_cnt - r0), 32'd2);

      r0 = req_cnt;
      start_job(32'h1C010200, 6, 1'b0, 1'b1);
      repeat (2) tick();
      start_i     = 1'b1;
      num_exp_i   = 16'd3;
      base_addr_i = 32'h0000_4000;
      tick();
      start_i     = 1'b0;
      finish_job("seq6");
      chk("seq6_reqs", 32'(req_cnt - r0), 32'd2);

      r0 = req_cnt;
      b0 = busy_cnt;
      d0 = done_cnt;
      exps.delete();
      job_id++;
      start_i   = 1'b1;
      num_exp_i = 16'd0;
      @(negedge clk);
      #1;
      chk("zero_done_early", 32'(done_o), 32'd0);
      tick();
      start_i = 1'b0;
      @(negedge clk);
      #1;
      chk("zero_done", 32'(done_o), 32'd1);
      repeat (3) tick();
      chk("zero_busy_cycles", 32'(busy_cnt - b0), 32'd1);
      chk("zero_no_req", 32'(req_cnt - r0), 32'd0);
      chk("zero_one_done", 32'(done_cnt - d0), 32'd1);

      b0           = stall_cnt;
      stall_cycles = 5;
      start_job(32'h1C010100, 8, 1'b0, 1'b1);
      finish_job("stall");
      chk("stall_cycles", 32'(stall_cnt - b0), 32'd5);
      stall_cycles = 0;

      start_job(32'hFFFFFFFC, 8, 1'b1, 1'b1);
      finish_job("wrap");

      start_job(32'h1C010301, 1, 1'b1, 1'b1);
      finish_job("single");

      r0 = req_cnt;
      start_job(32'h1C010400, 8, 1'b1, 1'b0);
      t = 0;
      while (!(prod_job == job_id && accepted >= 2) && t < 200) begin
         tick();
         t++;
      end
      chk("clear_reached_two", 32'(accepted >= 2), 32'd1);
      clear_i = 1'b1;
      tick();
      clear_i = 1'b0;
      exps.delete();
      job_id++;
      repeat (10) tick();
      chk("clear_no_req", 32'(req_cnt - r0), 32'd0);
      chk("clear_no_done", 32'(done_cnt - d0), 32'd0);
      chk("clear_idle", 32'(busy_o), 32'd0);
      clear_i   = 1'b1;
      start_i   = 1'b1;
      num_exp_i = 16'd4;
      tick();
      clear_i = 1'b0;
      start_i = 1'b0;
      tick();
      chk("clear_start_ignored", 32'(busy_o), 32'd0);
      start_job(32'h1C010500, 4, 1'b1, 1'b1);
      finish_job("after_clear");

      val_pct = 60;
      gnt_pct = 60;
      for (int j = 0; j < 12; j++) begin
         start_job($urandom(), $urandom_range(40, 1), 1'b1, 1'b1);
         finish_job("rand");
      end
      start_job($urandom(), 300, 1'b1, 1'b1);
      finish_job("long");

      gnt_pct = 0;
      start_job(32'h1C010600, 4, 1'b1, 1'b1);
      t = 0;
      while (!tcdm_req_o && t < 200) begin
         tick();
         t++;
      end
      chk("arst_reached_write", 32'(tcdm_req_o), 32'd1);
      #3;
      rst_ni = 1'b0;
      #1;
      chk("arst_req_dropped", 32'(tcdm_req_o), 32'd0);
      chk("arst_busy", 32'(busy_o), 32'd0);
      sb.delete();
      exps.delete();
      job_id++;
      repeat (2) tick();
      rst_ni = 1'b1;
      repeat (2) tick();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
